// File: rtl/mod2011_pp_accumulator_if.sv
// mod2011_pp_accumulator_if
//   Stream bundle between the digit-product tables (producer of partial
//   residues) and the mod-2011 accumulator, plus the result stream to the
//   downstream consumer.
//
//   in_valid   producer -> acc   partial residue present
//   in_ready   acc -> producer   accumulator accepts a term this cycle
//   in_data    producer -> acc   11-bit partial residue, 0..2047
//   out_valid  acc -> consumer   frame result available
//   out_ready  consumer -> acc   consumer takes the result
//   out_data   acc -> consumer   11-bit reduced result, 0..2010
//
//   master: the environment side (drives terms, accepts results)
//   slave : the accumulator side
interface mod2011_pp_accumulator_if;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/mod2011_pp_accumulator.sv
// mod2011_pp_accumulator
//   Sums TERMS partial residues per frame modulo 2011 and presents the
//   reduced result on a registered valid/ready output.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   ACC   | accepting terms; in_ready high, running sum in acc_q
//   DONE  | frame result held on out_data/out_valid until handshake
//
//   Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   clr    synchronous frame abort (priority over a same-cycle accept)
//   bus    slave side of mod2011_pp_accumulator_if (term in, result out)
//   busy   at least one term of the current frame has been accepted
module mod2011_pp_accumulator #(
    parameter int TERMS = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clr,
    mod2011_pp_accumulator_if.slave        bus,
    output logic                           busy
);

    // Modulus is fixed for this datapath, hence not a parameter.
    localparam logic [10:0] MOD      = 11'd2011;
    localparam logic [11:0] MOD_W    = 12'd2011;
    localparam logic [5:0]  LAST_CNT = 6'(TERMS - 1);

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] acc_q, acc_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        out_valid_q, out_valid_d;
    logic [10:0] out_data_q, out_data_d;

    logic [10:0] term_red;
    logic [11:0] sum;
    logic [10:0] sum_red;
    logic        accept;

    // Terms above the modulus only span 2011..2047, so a single
    // conditional subtract fully reduces them.
    assign term_red = (bus.in_data >= MOD) ? (bus.in_data - MOD) : bus.in_data;

    // acc and term_red are both <= 2010, so sum <= 4020 and one
    // conditional subtract brings it back into 0..2010.
    assign sum     = {1'b0, acc_q} + {1'b0, term_red};
    assign sum_red = 11'((sum >= MOD_W) ? (sum - MOD_W) : sum);

    assign accept  = bus.in_valid && (state_q == ACC);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (clr) begin
            // Abort wins: the term presented this cycle is discarded and a
            // pending result is dropped without a handshake.
            acc_d = '0;
            cnt_d = '0;
            if (state_q == DONE) begin
                out_valid_d = 1'b0;
                state_d     = ACC;
            end
        end else begin
            case (state_q)
                ACC: begin
                    if (accept) begin
                        if (cnt_q == LAST_CNT) begin
                            out_data_d  = sum_red;
                            out_valid_d = 1'b1;
                            acc_d       = '0;
                            cnt_d       = '0;
                            state_d     = DONE;
                        end else begin
                            acc_d = sum_red;
                            cnt_d = cnt_q + 6'd1;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = ACC;
                    end
                end
                default: begin
                    state_d = ACC;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // in_ready depends on state only, never on in_valid.
    assign bus.in_ready  = (state_q == ACC);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign busy          = (state_q == ACC) && (cnt_q != 6'd0);

endmodule

// File: tb/tb_mod2011_pp_accumulator.sv
module tb_mod2011_pp_accumulator;

    localparam int TERMS = 16;
    localparam int MODV  = 2011;

    logic clk;
    logic rst_n;
    logic clr;
    logic busy;

    mod2011_pp_accumulator_if bus ();

    mod2011_pp_accumulator #(.TERMS(TERMS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus.slave),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Frame-level reference: result is the plain integer sum of raw terms
    // taken modulo 2011, published once TERMS terms have been taken.
    int m_sum;
    int m_cnt;
    bit m_done;
    bit m_ov;
    int m_od;

    typedef struct {
        int term;
        int expect_out;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sum  = 0;
        m_cnt  = 0;
        m_done = 0;
        m_ov   = 0;
        m_od   = 0;
    endtask

    // Called just after a falling edge: drive, advance model, clock, compare.
    task automatic step(input bit v, input int d, input bit ordy, input bit c);
        bus.in_valid  = v;
        bus.in_data   = 11'(d);
        bus.out_ready = ordy;
        clr           = c;
        if (c) begin
            m_sum = 0;
            m_cnt = 0;
            if (m_done) begin
                m_ov   = 0;
                m_done = 0;
            end
        end else if (!m_done) begin
            if (v) begin
                m_sum += d;
                m_cnt++;
                if (m_cnt == TERMS) begin
                    m_od   = m_sum % MODV;
                    m_ov   = 1;
                    m_done = 1;
                    m_sum  = 0;
                    m_cnt  = 0;
                end
            end
        end else if (ordy) begin
            m_ov   = 0;
            m_done = 0;
        end
        @(posedge clk);
        @(negedge clk);
        check("out_valid", int'(bus.out_valid), int'(m_ov));
        check("out_data", int'(bus.out_data), m_od);
        check("in_ready", int'(bus.in_ready), int'(!m_done));
        check("busy", int'(busy), int'(!m_done && m_cnt != 0));
    endtask

    task automatic frame(input int d, input bit ordy);
        for (int k = 0; k < TERMS; k++) step(1'b1, d, ordy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{term: 2010, expect_out: 1995};
        vecs[1] = '{term: 2047, expect_out: 576};
        vecs[2] = '{term: 0,    expect_out: 0};
        vecs[3] = '{term: 5,    expect_out: 80};
        vecs[4] = '{term: 1,    expect_out: 16};
        vecs[5] = '{term: 2011, expect_out: 0};
        vecs[6] = '{term: 1005, expect_out: 2003};
        vecs[7] = '{term: 2,    expect_out: 32};

        rst_n         = 1'b0;
        clr           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_data", int'(bus.out_data), 0);
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", int'(bus.in_ready), 1);

        // Table-driven constant-term frames, result consumed immediately.
        for (int i = 0; i < 8; i++) begin
            frame(vecs[i].term, 1'b1);
            check($sformatf("vec%0d_valid", i), int'(bus.out_valid), 1);
            check($sformatf("vec%0d_data", i), int'(bus.out_data), vecs[i].expect_out);
            check($sformatf("vec%0d_inrdy_done", i), int'(bus.in_ready), 0);
            step(1'b0, 0, 1'b1, 1'b0);
            check($sformatf("vec%0d_inrdy_back", i), int'(bus.in_ready), 1);
        end

        // s == 2011 wrap boundary.
        step(1'b1, 1000, 1'b0, 1'b0);
        step(1'b1, 1011, 1'b0, 1'b0);
        check("wrap_busy", int'(busy), 1);
        for (int k = 0; k < TERMS - 2; k++) step(1'b1, 0, 1'b0, 1'b0);
        check("wrap_data", int'(bus.out_data), 0);
        check("wrap_valid", int'(bus.out_valid), 1);
        step(1'b0, 0, 1'b1, 1'b0);

        // Backpressure: result held while producer keeps offering terms.
        frame(5, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 7, 1'b0, 1'b0);
            check("bp_data", int'(bus.out_data), 80);
            check("bp_valid", int'(bus.out_valid), 1);
            check("bp_in_ready", int'(bus.in_ready), 0);
        end
        step(1'b0, 0, 1'b1, 1'b0);
        check("bp_release_valid", int'(bus.out_valid), 0);

        // clr mid-frame, with a term offered on the same cycle.
        for (int k = 0; k < 7; k++) step(1'b1, 100, 1'b1, 1'b0);
        step(1'b1, 500, 1'b1, 1'b1);
        check("clr_busy", int'(busy), 0);
        frame(1, 1'b0);
        check("clr_frame_data", int'(bus.out_data), 16);
        // clr while DONE drops the result.
        step(1'b0, 0, 1'b0, 1'b1);
        check("clr_done_valid", int'(bus.out_valid), 0);
        check("clr_done_in_ready", int'(bus.in_ready), 1);

        // Asynchronous reset in the middle of a cycle after 9 terms.
        for (int k = 0; k < 9; k++) step(1'b1, 50, 1'b1, 1'b0);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_out_valid", int'(bus.out_valid), 0);
        check("arst_out_data", int'(bus.out_data), 0);
        check("arst_in_ready", int'(bus.in_ready), 1);
        check("arst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        frame(2, 1'b0);
        check("arst_frame_data", int'(bus.out_data), 32);
        step(1'b0, 0, 1'b1, 1'b0);

        // Randomised traffic against the frame-level model.
        for (int n = 0; n < 600; n++) begin
            int r;
            int d;
            bit v;
            bit ordy;
            bit c;
            v = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            if (r < 2)      d = 2011 + $urandom_range(0, 36);
            else if (r < 3) d = 2010;
            else if (r < 4) d = 2047;
            else if (r < 5) d = 0;
            else            d = $urandom_range(0, 2047);
            ordy = ($urandom_range(0, 2) != 0);
            c    = ($urandom_range(0, 60) == 0);
            step(v, d, ordy, c);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
